// File: rtl/cordic_phase_sequencer.sv
// cordic_phase_sequencer
//   Upstream driver for cordic_sincos. A 32-bit NCO phase (2^32 = 2*pi) is
//   offset, then folded to a quadrant plus a residual. The residual is scaled
//   to a Q2.30 angle in [0, pi/2), which keeps the CORDIC inside its
//   convergence range. The block then runs the CORDIC, un-folds the quadrant
//   onto the result and offers the sample over a valid/ready handshake.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   enable            run request
//   ftw               phase increment per issued sample
//   phase_offset      added to the accumulator when forming each angle
//   clear_err         clears err_timeout (a timeout on the same edge wins)
//   cordic_start      one-cycle start pulse (high exactly in ISSUE)
//   cordic_theta      Q2.30 angle, stable between start pulses
//   cordic_sin/cos    Q2.30 CORDIC results, qualified by cordic_done
//   sin_out/cos_out   full-circle Q2.30 sample
//   sample_valid      sample presented (HOLD)
//   sample_ready      downstream accepts the sample
//   busy              any state other than IDLE
//   err_timeout       sticky; cordic_done never arrived
module cordic_phase_sequencer #(
    parameter logic [31:0] PI_HALF_Q30    = 32'h6487ED51,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] ftw,
    input  logic [31:0] phase_offset,
    input  logic        clear_err,
    output logic        cordic_start,
    output logic [31:0] cordic_theta,
    input  logic [31:0] cordic_sin,
    input  logic [31:0] cordic_cos,
    input  logic        cordic_done,
    output logic [31:0] sin_out,
    output logic [31:0] cos_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        err_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state, state_nxt;
    logic [31:0]   acc;
    logic [1:0]    quad;
    logic [CW-1:0] cnt;
    logic          timeout;
    logic [31:0]   phase;
    logic [61:0]   prod;
    logic [31:0]   theta_nxt;
    logic [31:0]   sin_nxt, cos_nxt;

    // Two's-complement negate; the most negative code saturates instead of
    // wrapping back onto itself.
    function automatic logic [31:0] sneg(input logic [31:0] x);
        return (x == 32'h80000000) ? 32'h7FFFFFFF : (~x + 32'd1);
    endfunction

    assign phase = acc + phase_offset;
    assign prod  = {32'd0, phase[29:0]} * {30'd0, PI_HALF_Q30};
    // r < 2^30 and pi/2 < 2^31 keep prod below 2^61, so the top bit of the
    // shifted product is always 0: this is {1'b0, prod[60:30]}, truncated.
    assign theta_nxt = 32'(prod >> 30);

    // The counter value after this cycle would reach TIMEOUT_CYCLES.
    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        sin_nxt = cordic_sin;
        cos_nxt = cordic_cos;
        case (quad)
            2'd1: begin sin_nxt = cordic_cos;       cos_nxt = sneg(cordic_sin); end
            2'd2: begin sin_nxt = sneg(cordic_sin); cos_nxt = sneg(cordic_cos); end
            2'd3: begin sin_nxt = sneg(cordic_cos); cos_nxt = cordic_sin;       end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (enable) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (cordic_done)  state_nxt = HOLD;
                else if (timeout) state_nxt = IDLE;
            end
            HOLD:  if (sample_ready) state_nxt = enable ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            quad         <= '0;
            cnt          <= '0;
            cordic_start <= 1'b0;
            cordic_theta <= '0;
            sin_out      <= '0;
            cos_out      <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state <= state_nxt;
            // ISSUE is only entered from IDLE or HOLD, so this is a single pulse.
            cordic_start <= (state_nxt == ISSUE);
            if (state_nxt == ISSUE) begin
                cordic_theta <= theta_nxt;
                quad         <= phase[31:30];
                acc          <= acc + ftw;
            end

            if (state == WAIT && !cordic_done && !timeout)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;

            if (state == WAIT && cordic_done) begin
                sin_out <= sin_nxt;
                cos_out <= cos_nxt;
            end

            if (state == WAIT && !cordic_done && timeout)
                err_timeout <= 1'b1;
            else if (clear_err)
                err_timeout <= 1'b0;
        end
    end

    assign sample_valid = (state == HOLD);
    assign busy         = (state != IDLE);

endmodule
